// File: rtl/demux_reg.sv
`default_nettype none
// ============================================================================
// Module   : demux_reg
// Purpose  : Registered 1-to-2 valid/ready demultiplexer with one output slot
//            per port. Define DEMUX_COUNT_EN to build per-port transfer counters.
// Revision : 1.0
// ============================================================================
module demux_reg #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 sel,
    output logic                 a_valid,
    input  logic                 a_ready,
    output logic [WIDTH-1:0]     a_data,
    output logic                 b_valid,
    input  logic                 b_ready,
    output logic [WIDTH-1:0]     b_data,
    output logic [CNT_WIDTH-1:0] a_count,
    output logic [CNT_WIDTH-1:0] b_count
);

    logic a_fire;
    logic b_fire;
    logic a_load;
    logic b_load;

    assign a_fire   = a_valid && a_ready;
    assign b_fire   = b_valid && b_ready;
    // A slot can take a new word when empty or being drained this same cycle.
    assign in_ready = sel ? (!b_valid || b_ready) : (!a_valid || a_ready);
    assign a_load   = in_valid && in_ready && !sel;
    assign b_load   = in_valid && in_ready &&  sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_data  <= '0;
        end else if (a_load) begin
            a_valid <= 1'b1;
            a_data  <= in_data;
        end else if (a_fire) begin
            a_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid <= 1'b0;
            b_data  <= '0;
        end else if (b_load) begin
            b_valid <= 1'b1;
            b_data  <= in_data;
        end else if (b_fire) begin
            b_valid <= 1'b0;
        end
    end

`ifdef DEMUX_COUNT_EN
    logic [CNT_WIDTH-1:0] a_cnt;
    logic [CNT_WIDTH-1:0] b_cnt;

    // Counters wrap naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt <= '0;
            b_cnt <= '0;
        end else begin
            if (a_fire) a_cnt <= a_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            if (b_fire) b_cnt <= b_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign a_count = a_cnt;
    assign b_count = b_cnt;
`else
    assign a_count = '0;
    assign b_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_reg
// Purpose  : Directed scoreboard bench for demux_reg (honours DEMUX_COUNT_EN).
// Revision : 1.0
// ============================================================================
module tb_demux_reg;

    localparam int WIDTH     = 32;
    localparam int CNT_WIDTH = 2;

    logic                 clk      = 1'b0;
    logic                 rst_n    = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 sel      = 1'b0;
    logic                 a_ready  = 1'b0;
    logic                 b_ready  = 1'b0;
    logic [WIDTH-1:0]     in_data  = '0;
    logic                 in_ready;
    logic                 a_valid;
    logic                 b_valid;
    logic [WIDTH-1:0]     a_data;
    logic [WIDTH-1:0]     b_data;
    logic [CNT_WIDTH-1:0] a_count;
    logic [CNT_WIDTH-1:0] b_count;

    demux_reg #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .sel(sel),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .a_count(a_count), .b_count(b_count)
    );

    always #5 clk = ~clk;

    // Scoreboard: words expected in each slot, last drained word, transfer counts.
    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    logic [WIDTH-1:0] last_a = '0;
    logic [WIDTH-1:0] last_b = '0;
    int unsigned      ca = 0;
    int unsigned      cb = 0;
    int               errors = 0;
    int               checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_ready();
        return sel ? (qb.size() == 0 || b_ready) : (qa.size() == 0 || a_ready);
    endfunction

    task automatic check_all(input string tag);
        logic [WIDTH-1:0] ea;
        logic [WIDTH-1:0] eb;
        int unsigned      eca;
        int unsigned      ecb;
        ea = (qa.size() != 0) ? qa[0] : last_a;
        eb = (qb.size() != 0) ? qb[0] : last_b;
`ifdef DEMUX_COUNT_EN
        eca = ca;
        ecb = cb;
`else
        eca = 0;
        ecb = 0;
`endif
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(exp_ready()));
        chk({tag, ".a_valid"},  64'(a_valid),  64'(qa.size() != 0));
        chk({tag, ".b_valid"},  64'(b_valid),  64'(qb.size() != 0));
        chk({tag, ".a_data"},   64'(a_data),   64'(ea));
        chk({tag, ".b_data"},   64'(b_data),   64'(eb));
        chk({tag, ".a_count"},  64'(a_count),  64'(eca));
        chk({tag, ".b_count"},  64'(b_count),  64'(ecb));
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        last_a = '0;
        last_b = '0;
        ca = 0;
        cb = 0;
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase one cycle later.
    task automatic step(input string tag, input logic iv, input logic s,
                        input logic [WIDTH-1:0] d, input logic ar, input logic br);
        logic acc;
        in_valid = iv;
        sel      = s;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
        #2;
        check_all(tag);
        acc = iv && exp_ready();
        @(posedge clk);
        if (qa.size() != 0 && ar) begin
            last_a = qa.pop_front();
            ca = (ca + 1) % (1 << CNT_WIDTH);
        end
        if (qb.size() != 0 && br) begin
            last_b = qb.pop_front();
            cb = (cb + 1) % (1 << CNT_WIDTH);
        end
        if (acc) begin
            if (s) qb.push_back(d);
            else   qa.push_back(d);
        end
        #1;
    endtask

    initial begin
        // Reset state with sel=0 and both consumers stalled.
        #2;
        check_all("reset");
        @(posedge clk);
        #1;
        check_all("reset_hold");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word to A, drained immediately.
        step("t2_send",  1'b1, 1'b0, 32'd1, 1'b1, 1'b0);
        step("t2_out",   1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        step("t2_empty", 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

        // B stalled while A keeps flowing, then B released in order.
        step("t3_b2",    1'b1, 1'b1, 32'd2, 1'b1, 1'b0);
        step("t3_b3blk", 1'b1, 1'b1, 32'd3, 1'b1, 1'b0);
        step("t3_a4",    1'b1, 1'b0, 32'd4, 1'b1, 1'b0);
        step("t3_a4out", 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        step("t3_b3rel", 1'b1, 1'b1, 32'd3, 1'b0, 1'b1);
        step("t3_b3out", 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        step("t3_idle",  1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

        // Full-throughput alternating stream.
        step("t4_5",     1'b1, 1'b0, 32'd5, 1'b1, 1'b1);
        step("t4_6",     1'b1, 1'b1, 32'd6, 1'b1, 1'b1);
        step("t4_7",     1'b1, 1'b0, 32'd7, 1'b1, 1'b1);
        step("t4_8",     1'b1, 1'b1, 32'd8, 1'b1, 1'b1);
        step("t4_tail1", 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        step("t4_tail2", 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

        // in_valid low must not load even with data and sel present.
        step("nold",     1'b0, 1'b1, 32'hdead_beef, 1'b0, 1'b0);
        step("nold_chk", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

        // Async reset while B holds a stalled word.
        step("t5_b9",    1'b1, 1'b1, 32'd9, 1'b0, 1'b0);
        step("t5_hold",  1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t5_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("t5_nostale", 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

        // Five A and two B transfers; counters wrap at 2^CNT_WIDTH.
        for (int k = 0; k < 5; k++) step("t6_a", 1'b1, 1'b0, 32'(16 + k), 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) step("t6_b", 1'b1, 1'b1, 32'(32 + k), 1'b1, 1'b1);
        step("t6_drain", 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        step("t6_count", 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
